// File: rtl/stage_tracker.sv
`default_nettype none
// ============================================================================
// Module      : stage_tracker
// Description : Per-stage trace element tracker. Buffers trace elements in a
//               small FIFO, timestamps each element's residency in one
//               pipeline stage, marks elements squashed by a flush and hands
//               them downstream on a valid/ready handshake.
//               Optional macro STAGE_TRACKER_STATS_EN adds saturating
//               handshake and stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_tracker #(
    parameter int TRACE_WIDTH = 64,
    parameter int TIME_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TIME_WIDTH-1:0]          counter,
    input  logic                           in_valid,
    input  logic [TRACE_WIDTH-1:0]         in_data,
    input  logic                           in_pass,
    input  logic                           stage_done,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [TRACE_WIDTH-1:0]         out_data,
    output logic                           out_pass,
    output logic [TIME_WIDTH-1:0]          out_t_start,
    output logic [TIME_WIDTH-1:0]          out_t_end,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy,
    output logic                           overflow
`ifdef STAGE_TRACKER_STATS_EN
    ,
    output logic [TIME_WIDTH-1:0]          stat_emitted,
    output logic [TIME_WIDTH-1:0]          stat_stall
`endif
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(QUEUE_DEPTH);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [TRACE_WIDTH-1:0] r_fifo_data [QUEUE_DEPTH];
    logic                   r_fifo_pass [QUEUE_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_not_empty;
    logic                   w_push;
    logic                   w_pop;

    // ------------------------------------------------------------------------
    // Work register: the element currently resident in the stage
    // ------------------------------------------------------------------------
    logic [TRACE_WIDTH-1:0] r_data;
    logic                   r_pass;
    logic [TIME_WIDTH-1:0]  r_t_start;
    logic [TIME_WIDTH-1:0]  r_t_end;

    logic                   w_out_valid;

    // Pop decisions use the registered count only, so an element pushed this
    // cycle is never visible to the FSM until the next cycle (no bypass).
    assign w_full      = (r_count == c_depth);
    assign w_not_empty = (r_count != '0);

    // A push into a full FIFO survives only if a pop frees a slot this cycle.
    assign w_push      = in_valid && (!w_full || w_pop);

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= in_data;
            r_fifo_pass[r_wr_ptr] <= in_pass;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state, pop request and output-valid decode
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (stage_done) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    // Back-to-back: load the next element on the accept edge
                    // so the stage never passes through IDLE.
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_ACTIVE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Work register load on pop; flush marking and end stamp while ACTIVE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data    <= '0;
            r_pass    <= 1'b0;
            r_t_start <= '0;
            r_t_end   <= '0;
        end else if (w_pop) begin
            r_data    <= r_fifo_data[r_rd_ptr];
            r_pass    <= r_fifo_pass[r_rd_ptr];
            r_t_start <= counter;
        end else if (r_state == S_ACTIVE) begin
            // Flush and stage_done in the same cycle both take effect.
            if (flush) begin
                r_pass <= 1'b1;
            end
            if (stage_done) begin
                r_t_end <= counter;
            end
        end
    end

    // Raw timestamps are passed out unmodified; wrap is resolved downstream.
    assign out_valid   = w_out_valid;
    assign out_data    = r_data;
    assign out_pass    = r_pass;
    assign out_t_start = r_t_start;
    assign out_t_end   = r_t_end;
    assign occupancy   = r_count;
    assign overflow    = r_overflow;

`ifdef STAGE_TRACKER_STATS_EN
    localparam logic [TIME_WIDTH-1:0] c_time_one = TIME_WIDTH'(1);

    logic [TIME_WIDTH-1:0] r_stat_emitted;
    logic [TIME_WIDTH-1:0] r_stat_stall;

    // Saturating counters of completed handshakes and stalled ACTIVE cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_emitted <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_out_valid && out_ready && (r_stat_emitted != '1)) begin
                r_stat_emitted <= r_stat_emitted + c_time_one;
            end
            if ((r_state == S_ACTIVE) && !stage_done && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + c_time_one;
            end
        end
    end

    assign stat_emitted = r_stat_emitted;
    assign stat_stall   = r_stat_stall;
`endif

endmodule
`default_nettype wire
